// File: rtl/dualport_mem_arbiter.sv
// Two-core front end for a shared dual-port RAM: per-port req/ack sequencing, same-address
// hazard serialisation with rotating priority, range checking and read-data capture.
module dualport_mem_arbiter #(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MEM_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              core1_req,
    input  logic              core1_we,
    input  logic [ADDR_W-1:0] core1_addr,
    input  logic [DATA_W-1:0] core1_wdata,
    output logic              core1_ack,
    output logic              core1_err,
    output logic [DATA_W-1:0] core1_rdata,
    output logic              core1_busy,

    input  logic              core2_req,
    input  logic              core2_we,
    input  logic [ADDR_W-1:0] core2_addr,
    input  logic [DATA_W-1:0] core2_wdata,
    output logic              core2_ack,
    output logic              core2_err,
    output logic [DATA_W-1:0] core2_rdata,
    output logic              core2_busy,

    output logic              ram_write_en1,
    output logic              ram_write_en2,
    output logic              ram_read_en1,
    output logic              ram_read_en2,
    output logic [ADDR_W-1:0] ram_addr1,
    output logic [ADDR_W-1:0] ram_addr2,
    output logic [DATA_W-1:0] ram_data_in1,
    output logic [DATA_W-1:0] ram_data_in2,
    input  logic [DATA_W-1:0] ram_data_out1,
    input  logic [DATA_W-1:0] ram_data_out2,

    output logic [15:0]       conflict_cnt
);

    localparam int NP = 2;

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    logic              req_in   [NP];
    logic              we_in    [NP];
    logic [ADDR_W-1:0] addr_in  [NP];
    logic [DATA_W-1:0] wdata_in [NP];
    logic [DATA_W-1:0] dout_in  [NP];

    state_e            state_q  [NP];
    state_e            state_d  [NP];
    logic              we_q     [NP];
    logic              we_d     [NP];
    logic [ADDR_W-1:0] addr_q   [NP];
    logic [ADDR_W-1:0] addr_d   [NP];
    logic [DATA_W-1:0] wdata_q  [NP];
    logic [DATA_W-1:0] wdata_d  [NP];
    // go_q marks the cycle a port owns its RAM port and may leave ISSUE
    logic              go_q     [NP];
    logic              go_d     [NP];

    logic              hazard;
    logic              prio_q, prio_d;
    logic [15:0]       cnt_q, cnt_d;

    logic              wen_q    [NP];
    logic              wen_d    [NP];
    logic              ren_q    [NP];
    logic              ren_d    [NP];
    logic [ADDR_W-1:0] raddr_q  [NP];
    logic [ADDR_W-1:0] raddr_d  [NP];
    logic [DATA_W-1:0] din_q    [NP];
    logic [DATA_W-1:0] din_d    [NP];
    logic              ack_q    [NP];
    logic              ack_d    [NP];
    logic              err_q    [NP];
    logic              err_d    [NP];
    logic [DATA_W-1:0] rdata_q  [NP];
    logic [DATA_W-1:0] rdata_d  [NP];
    logic              busy_q   [NP];
    logic              busy_d   [NP];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < MEM_DEPTH;
    endfunction

    assign req_in[0]   = core1_req;
    assign req_in[1]   = core2_req;
    assign we_in[0]    = core1_we;
    assign we_in[1]    = core2_we;
    assign addr_in[0]  = core1_addr;
    assign addr_in[1]  = core2_addr;
    assign wdata_in[0] = core1_wdata;
    assign wdata_in[1] = core2_wdata;
    assign dout_in[0]  = ram_data_out1;
    assign dout_in[1]  = ram_data_out2;

    // State register and latched request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                state_q[i] <= StIdle;
                we_q[i]    <= 1'b0;
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                go_q[i]    <= 1'b0;
            end
            prio_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                state_q[i] <= state_d[i];
                we_q[i]    <= we_d[i];
                addr_q[i]  <= addr_d[i];
                wdata_q[i] <= wdata_d[i];
                go_q[i]    <= go_d[i];
            end
            prio_q <= prio_d;
            cnt_q  <= cnt_d;
        end
    end

    // Next state, including the arbitration decision for the coming cycle
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            state_d[i] = state_q[i];
            we_d[i]    = we_q[i];
            addr_d[i]  = addr_q[i];
            wdata_d[i] = wdata_q[i];
            unique case (state_q[i])
                StIdle: begin
                    if (req_in[i]) begin
                        state_d[i] = StIssue;
                        we_d[i]    = we_in[i];
                        addr_d[i]  = addr_in[i];
                        wdata_d[i] = wdata_in[i];
                    end
                end
                StIssue: begin
                    if (go_q[i]) state_d[i] = StResp;
                end
                StResp:  state_d[i] = StIdle;
                default: state_d[i] = StIdle;
            endcase
        end

        hazard = (state_d[0] == StIssue) && (state_d[1] == StIssue) &&
                 (addr_d[0] == addr_d[1]) && (we_d[0] || we_d[1]);

        // prio_q = 0 favours core 1, 1 favours core 2
        go_d[0] = (state_d[0] == StIssue) && !(hazard && prio_q);
        go_d[1] = (state_d[1] == StIssue) && !(hazard && !prio_q);

        prio_d = hazard ? ~prio_q : prio_q;
        cnt_d  = (hazard && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
    end

    // Registered-output next values
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            wen_d[i]   = 1'b0;
            ren_d[i]   = 1'b0;
            raddr_d[i] = '0;
            din_d[i]   = '0;
            if (go_d[i] && in_range(addr_d[i])) begin
                wen_d[i]   = we_d[i];
                ren_d[i]   = !we_d[i];
                raddr_d[i] = addr_d[i];
                din_d[i]   = we_d[i] ? wdata_d[i] : '0;
            end

            ack_d[i] = (state_q[i] == StIssue) && go_q[i];
            err_d[i] = ack_d[i] && !in_range(addr_q[i]);

            // RAM data becomes valid during RESP, one cycle after the read strobe
            rdata_d[i] = rdata_q[i];
            if ((state_q[i] == StResp) && !we_q[i] && in_range(addr_q[i])) begin
                rdata_d[i] = dout_in[i];
            end

            busy_d[i] = (state_d[i] != StIdle);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                wen_q[i]   <= 1'b0;
                ren_q[i]   <= 1'b0;
                raddr_q[i] <= '0;
                din_q[i]   <= '0;
                ack_q[i]   <= 1'b0;
                err_q[i]   <= 1'b0;
                rdata_q[i] <= '0;
                busy_q[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                wen_q[i]   <= wen_d[i];
                ren_q[i]   <= ren_d[i];
                raddr_q[i] <= raddr_d[i];
                din_q[i]   <= din_d[i];
                ack_q[i]   <= ack_d[i];
                err_q[i]   <= err_d[i];
                rdata_q[i] <= rdata_d[i];
                busy_q[i]  <= busy_d[i];
            end
        end
    end

    assign core1_ack     = ack_q[0];
    assign core1_err     = err_q[0];
    assign core1_rdata   = rdata_q[0];
    assign core1_busy    = busy_q[0];
    assign core2_ack     = ack_q[1];
    assign core2_err     = err_q[1];
    assign core2_rdata   = rdata_q[1];
    assign core2_busy    = busy_q[1];

    assign ram_write_en1 = wen_q[0];
    assign ram_write_en2 = wen_q[1];
    assign ram_read_en1  = ren_q[0];
    assign ram_read_en2  = ren_q[1];
    assign ram_addr1     = raddr_q[0];
    assign ram_addr2     = raddr_q[1];
    assign ram_data_in1  = din_q[0];
    assign ram_data_in2  = din_q[1];

    assign conflict_cnt  = cnt_q;

endmodule
